// File: rtl/trace_checker.sv
// Self-checking trace monitor: compares retired-instruction channels against an
// expected-vector memory indexed by PC, with masking, fail counting and run control.
module trace_checker #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vec_we,
  input  logic [$clog2(DEPTH)-1:0]   vec_addr,
  input  logic [NCH*XLEN-1:0]        vec_data,
  input  logic [NCH*XLEN-1:0]        vec_mask,
  input  logic                       start,
  input  logic                       stop_on_fail,
  input  logic [XLEN-1:0]            end_pc,
  input  logic [CNT_W-1:0]           max_cycles,
  input  logic                       mon_valid,
  input  logic [XLEN-1:0]            mon_pc,
  input  logic [NCH*XLEN-1:0]        mon_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic                       err_valid,
  output logic [NCH:0]               err_mask,
  output logic [CNT_W-1:0]           fail_count,
  output logic [XLEN-1:0]            first_pc,
  output logic [NCH:0]               first_mask
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = NCH * XLEN;
  localparam int unsigned MW = NCH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e state_q, state_d;

  logic [DW-1:0]    exp_mem [DEPTH];
  logic [DW-1:0]    msk_mem [DEPTH];
  logic [DW-1:0]    rd_exp_q, rd_msk_q;

  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic             s1_inr_q, s1_inr_d;

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             err_valid_q, err_valid_d;
  logic [MW-1:0]    err_mask_q, err_mask_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [XLEN-1:0]  first_pc_q, first_pc_d;
  logic [MW-1:0]    first_mask_q, first_mask_d;

  logic [AW-1:0]    rd_idx;
  logic             mon_inr;
  logic [MW-1:0]    cmp_mask;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_sat;
  logic             beat_fail, end_hit, fail_stop, to_hit, go_done;

  assign rd_idx  = mon_pc[AW+1:2];
  assign mon_inr = (mon_pc[XLEN-1:AW+2] == '0);

  // Vector memory is not reset; writes are blocked while a run is active.
  always_ff @(posedge clk) begin
    if (vec_we && (state_q != ST_RUN)) begin
      exp_mem[vec_addr] <= vec_data;
      msk_mem[vec_addr] <= vec_mask;
    end
    rd_exp_q <= exp_mem[rd_idx];
    rd_msk_q <= msk_mem[rd_idx];
  end

  // S2 compare: out-of-range PC suppresses the per-channel compares.
  always_comb begin
    cmp_mask = '0;
    if (!s1_inr_q) begin
      cmp_mask[NCH] = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cmp_mask[c] = |((s1_data_q[c*XLEN +: XLEN] ^ rd_exp_q[c*XLEN +: XLEN])
                        & rd_msk_q[c*XLEN +: XLEN]);
      end
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < MW; i++) begin
      pop_cnt = pop_cnt + CNT_W'(cmp_mask[i]);
    end
    cnt_sum = {1'b0, fail_count_q} + {1'b0, pop_cnt};
    cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    s1_valid_d   = 1'b0;
    s1_pc_d      = s1_pc_q;
    s1_data_d    = s1_data_q;
    s1_inr_d     = s1_inr_q;
    cyc_d        = cyc_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    err_valid_d  = 1'b0;
    err_mask_d   = err_mask_q;
    fail_count_d = fail_count_q;
    first_pc_d   = first_pc_q;
    first_mask_d = first_mask_q;
    beat_fail    = s1_valid_q && (|cmp_mask);
    end_hit      = s1_valid_q && (s1_pc_q == end_pc);
    fail_stop    = stop_on_fail && beat_fail;
    to_hit       = 1'b0;
    go_done      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          cyc_d        = '0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          err_mask_d   = '0;
          fail_count_d = '0;
          first_pc_d   = '0;
          first_mask_d = '0;
        end
      end
      ST_RUN: begin
        cyc_d  = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        to_hit = (max_cycles != '0) && (cyc_d == max_cycles);
        if (s1_valid_q) begin
          err_mask_d = cmp_mask;
        end
        if (beat_fail) begin
          err_valid_d  = 1'b1;
          fail_count_d = cnt_sat;
          // A zero count means no failure has been seen yet in this run.
          if (fail_count_q == '0) begin
            first_pc_d   = s1_pc_q;
            first_mask_d = cmp_mask;
          end
        end
        go_done = end_hit || fail_stop || to_hit;
        if (go_done) begin
          state_d   = ST_DONE;
          timeout_d = to_hit && !end_hit;
          pass_d    = (fail_count_d == '0) && !timeout_d;
        end else if (mon_valid) begin
          s1_valid_d = 1'b1;
          s1_pc_d    = mon_pc;
          s1_data_d  = mon_data;
          s1_inr_d   = mon_inr;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      s1_valid_q   <= 1'b0;
      s1_pc_q      <= '0;
      s1_data_q    <= '0;
      s1_inr_q     <= 1'b0;
      cyc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_mask_q   <= '0;
      fail_count_q <= '0;
      first_pc_q   <= '0;
      first_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_pc_q      <= s1_pc_d;
      s1_data_q    <= s1_data_d;
      s1_inr_q     <= s1_inr_d;
      cyc_q        <= cyc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      err_valid_q  <= err_valid_d;
      err_mask_q   <= err_mask_d;
      fail_count_q <= fail_count_d;
      first_pc_q   <= first_pc_d;
      first_mask_q <= first_mask_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign err_valid  = err_valid_q;
  assign err_mask   = err_mask_q;
  assign fail_count = fail_count_q;
  assign first_pc   = first_pc_q;
  assign first_mask = first_mask_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: a table of isolated beats plus hand-written
// end, mask, stop-on-fail, timeout and reset sequences.
module tb_trace_checker;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              vec_we;
  logic [7:0]        vec_addr;
  logic [63:0]       vec_data;
  logic [63:0]       vec_mask;
  logic              start;
  logic              stop_on_fail;
  logic [31:0]       end_pc;
  logic [15:0]       max_cycles;
  logic              mon_valid;
  logic [31:0]       mon_pc;
  logic [63:0]       mon_data;
  logic              busy, done, pass, timeout, err_valid;
  logic [2:0]        err_mask, first_mask;
  logic [15:0]       fail_count;
  logic [31:0]       first_pc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [31:0] res;
    logic        ev;
    logic [2:0]  em;
    logic        dn;
  } vec_t;

  vec_t tbl [9];

  trace_checker #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr),
    .vec_data(vec_data), .vec_mask(vec_mask), .start(start),
    .stop_on_fail(stop_on_fail), .end_pc(end_pc), .max_cycles(max_cycles),
    .mon_valid(mon_valid), .mon_pc(mon_pc), .mon_data(mon_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_valid(err_valid), .err_mask(err_mask), .fail_count(fail_count),
    .first_pc(first_pc), .first_mask(first_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] pcn, input logic [31:0] res,
                      input logic [63:0] msk);
    vec_we   = 1'b1;
    vec_addr = 8'(idx);
    vec_data = {res, pcn};
    vec_mask = msk;
    tick();
    vec_we   = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] res);
    mon_valid = 1'b1;
    mon_pc    = pc;
    mon_data  = {res, pcn};
  endtask

  // Isolated beat: S1 edge, then S2 edge; results visible on return.
  task automatic beat(input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] res);
    drive(pc, pcn, res);
    tick();
    mon_valid = 1'b0;
    tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    tbl[0] = '{32'h0000_0000, 32'h4,   32'h100,  1'b0, 3'b000, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h8,   32'h5,    1'b1, 3'b010, 1'b0};
    tbl[2] = '{32'h0000_0004, 32'h10,  32'h7,    1'b1, 3'b001, 1'b0};
    tbl[3] = '{32'h0000_0000, 32'h0,   32'h0,    1'b1, 3'b011, 1'b0};
    tbl[4] = '{32'h0000_0400, 32'h4,   32'h100,  1'b1, 3'b100, 1'b0};
    tbl[5] = '{32'h0000_03FC, 32'h400, 32'hABCD, 1'b0, 3'b000, 1'b0};
    tbl[6] = '{32'h0000_0404, 32'h8,   32'h7,    1'b1, 3'b100, 1'b0};
    tbl[7] = '{32'hFFFF_FFFC, 32'h0,   32'h0,    1'b1, 3'b100, 1'b0};
    tbl[8] = '{32'h0000_0008, 32'hC,   32'h9,    1'b0, 3'b000, 1'b1};

    reset = 1'b0; vec_we = 1'b0; vec_addr = '0; vec_data = '0; vec_mask = '0;
    start = 1'b0; stop_on_fail = 1'b0; end_pc = '0; max_cycles = '0;
    mon_valid = 1'b0; mon_pc = '0; mon_data = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_fail_count", 64'(fail_count), 64'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    load(0,   32'h4,   32'h100,  '1);
    load(1,   32'h8,   32'h7,    '1);
    load(2,   32'hC,   32'h9,    '1);
    load(255, 32'h400, 32'hABCD, '1);

    // Table run: isolated beats, ending on the matching PC 8 beat.
    end_pc = 32'h8;
    start_run();
    chk("run_busy", 64'(busy), 64'h1);
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      beat(tbl[i].pc, tbl[i].pcn, tbl[i].res);
      exp_cnt += $countones(tbl[i].em);
      chk($sformatf("tbl%0d_err_valid", i), 64'(err_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_err_mask", i), 64'(err_mask), 64'(tbl[i].em));
      chk($sformatf("tbl%0d_fail_count", i), 64'(fail_count), 64'(exp_cnt));
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].dn));
    end
    chk("tbl_pass", 64'(pass), 64'h0);
    chk("tbl_first_pc", 64'(first_pc), 64'h4);
    chk("tbl_first_mask", 64'(first_mask), 64'h2);

    // Result channel masked off at PC 4.
    load(1, 32'h8, 32'h7, {32'h0, 32'hFFFF_FFFF});
    start_run();
    chk("mask_cleared_count", 64'(fail_count), 64'h0);
    beat(32'h4, 32'h8, 32'h55);
    chk("mask_dc_err_valid", 64'(err_valid), 64'h0);
    beat(32'h4, 32'h20, 32'h7);
    chk("mask_pcn_err_mask", 64'(err_mask), 64'h1);
    chk("mask_pcn_count", 64'(fail_count), 64'h1);
    beat(32'h8, 32'hC, 32'h9);
    chk("mask_done", 64'(done), 64'h1);

    // Back-to-back matching beats ending at PC 8.
    load(1, 32'h8, 32'h7, '1);
    start_run();
    chk("b2b_first_pc_clr", 64'(first_pc), 64'h0);
    drive(32'h0, 32'h4, 32'h100); tick();
    drive(32'h4, 32'h8, 32'h7);   tick();
    drive(32'h8, 32'hC, 32'h9);   tick();
    mon_valid = 1'b0;
    chk("b2b_not_done_yet", 64'(done), 64'h0);
    tick();
    chk("b2b_done", 64'(done), 64'h1);
    chk("b2b_busy", 64'(busy), 64'h0);
    chk("b2b_pass", 64'(pass), 64'h1);
    chk("b2b_count", 64'(fail_count), 64'h0);
    beat(32'h4, 32'h0, 32'h0);
    chk("done_ignore_err", 64'(err_valid), 64'h0);
    chk("done_ignore_count", 64'(fail_count), 64'h0);

    // Stop on first failure; the following beat is discarded.
    stop_on_fail = 1'b1;
    end_pc = 32'hDEAD_0000;
    start_run();
    drive(32'h4, 32'h8, 32'h5); tick();
    drive(32'h8, 32'h0, 32'h0); tick();
    mon_valid = 1'b0;
    chk("sof_done", 64'(done), 64'h1);
    chk("sof_err_valid", 64'(err_valid), 64'h1);
    chk("sof_err_mask", 64'(err_mask), 64'h2);
    chk("sof_count", 64'(fail_count), 64'h1);
    chk("sof_pass", 64'(pass), 64'h0);
    chk("sof_first_pc", 64'(first_pc), 64'h4);
    tick();
    chk("sof_count_hold", 64'(fail_count), 64'h1);
    chk("sof_err_pulse", 64'(err_valid), 64'h0);
    stop_on_fail = 1'b0;

    // Timeout after 10 RUN cycles.
    max_cycles = 16'd10;
    start_run();
    repeat (9) tick();
    chk("to_before_done", 64'(done), 64'h0);
    chk("to_before_busy", 64'(busy), 64'h1);
    tick();
    chk("to_done", 64'(done), 64'h1);
    chk("to_timeout", 64'(timeout), 64'h1);
    chk("to_pass", 64'(pass), 64'h0);

    // Reset mid-run, then confirm memory survived.
    max_cycles = '0;
    end_pc = 32'h0;
    start_run();
    chk("restart_timeout_clr", 64'(timeout), 64'h0);
    beat(32'h400, 32'h0, 32'h0);
    chk("prereset_count", 64'(fail_count), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_pass", 64'(pass), 64'h0);
    chk("arst_timeout", 64'(timeout), 64'h0);
    chk("arst_err_valid", 64'(err_valid), 64'h0);
    chk("arst_err_mask", 64'(err_mask), 64'h0);
    chk("arst_count", 64'(fail_count), 64'h0);
    chk("arst_first_pc", 64'(first_pc), 64'h0);
    chk("arst_first_mask", 64'(first_mask), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    start_run();
    beat(32'h0, 32'h4, 32'h100);
    chk("mem_kept_done", 64'(done), 64'h1);
    chk("mem_kept_pass", 64'(pass), 64'h1);
    chk("mem_kept_count", 64'(fail_count), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Synthesizable, parametrised self-checking monitor for the RV32I core.
- Each beat, it compares NCH monitored channels against an expected-vector memory indexed by the word address of the PC. PCNext and Result are the default two channels.
- Supports per-bit don't-care masking, a saturating fail counter, first-failure capture, end-PC and timeout termination, and an optional stop-on-fail mode.
- Sits beside the core in FPGA or emulation builds, so checking no longer depends on a simulator-only bench.

Parameters:
- XLEN, 32, width of each channel and of the PC.
- NCH, 2, number of compared channels; channel 0 is PCNext, channel 1 is Result.
- DEPTH, 256, expected-vector entries (power of two); index = pc[$clog2(DEPTH)+1:2].
- CNT_W, 16, width of the fail counter and the cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock; reset is asynchronous and active-low.
- vec_we  in  1  expected-vector write strobe.
- vec_addr  in  $clog2(DEPTH)  write index.
- vec_data  in  NCH*XLEN  expected values; channel c occupies bits [c*XLEN +: XLEN].
- vec_mask  in  NCH*XLEN  compare enable per bit; 1 = compare, 0 = don't care.
- start  in  1  begin or restart a run.
- stop_on_fail  in  1  enter DONE on the first failing beat.
- end_pc  in  XLEN  PC value that terminates the run.
- max_cycles  in  CNT_W  timeout limit; 0 disables the timeout.
- mon_valid  in  1  beat valid, asserted once per retired instruction.
- mon_pc  in  XLEN  PC of the beat.
- mon_data  in  NCH*XLEN  observed channel values.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high.
- timeout  out  1  run ended by timeout.
- err_valid  out  1  one-cycle pulse for a failing beat.
- err_mask  out  NCH+1  bit c = channel c mismatched; bit NCH = out-of-range PC.
- fail_count  out  CNT_W  number of failing channel comparisons, saturating.
- first_pc  out  XLEN  PC of the first failing beat.
- first_mask  out  NCH+1  err_mask of the first failing beat.

Behaviour:
- Reset clears all of the following: FSM to IDLE; busy, done, pass, timeout, err_valid at 0; err_mask, fail_count, first_pc, first_mask at 0; the pipeline valid bit at 0.
- Reset does not clear vector memory contents.
- FSM states and transitions:
  - IDLE: start moves to RUN.
  - RUN: moves to DONE on end, fail-stop or timeout.
  - DONE: start moves to RUN.
  - Entering RUN clears the counters, first_* and timeout.
- vec_we writes data and mask in IDLE or DONE. Writes during RUN are ignored.
- Pipeline, stage S1: at edge N, if in RUN and mon_valid, the block registers pc, data and the in-range flag, and performs a synchronous memory read.
- Pipeline, stage S2: after edge N+1, the comparison results are visible on err_valid, err_mask and fail_count. Back-to-back beats every cycle are supported.
- Channel c mismatches when ((obs ^ exp) & mask) != 0.
- Out-of-range PC: pc[XLEN-1:$clog2(DEPTH)+2] != 0. This sets err_mask[NCH] only, suppresses the channel compares, and counts as 1 failure.
- fail_count adds popcount(err_mask) per failing beat and saturates at all-ones.
- first_pc and first_mask are written only on the first failing beat of a run.
- End of run:
  - When the S2 beat has pc == end_pc, that beat is still checked, then the FSM enters DONE.
  - pass = (fail_count == 0) && !timeout, evaluated including that final beat.
  - In DONE, new mon_valid beats are ignored.
- stop_on_fail = 1: the first failing beat's results are committed, then the FSM enters DONE with pass = 0. A beat already in S1 is discarded.
- Timeout: a cycle counter increments every RUN cycle. When it equals max_cycles (non-zero), the FSM enters DONE with timeout = 1 and pass = 0. The in-flight beat is discarded.
- Simultaneous events: end, fail-stop and timeout on the same cycle resolve as DONE with the failure counted; timeout is set only if end was not reached.
- start in RUN is ignored.
- reset mid-run aborts immediately to the reset state.

Test Plan:
- Load 3 vectors (PC 0, 4, 8) with full masks and end_pc = 8; feed matching beats -> done after beat 3 plus 2 cycles, pass = 1, fail_count = 0.
- Beat at PC 4 with Result 0x5 vs expected 0x7 -> err_valid one cycle after the S1 edge, err_mask = 3'b010, fail_count = 1, first_pc = 4, first_mask = 3'b010, pass = 0 at end.
- Result mask = 0 at PC 4 with differing Result -> no error; PCNext mismatch at the same PC -> err_mask = 3'b001.
- Beat with PC 0x400 (DEPTH = 256) -> err_mask = 3'b100, fail_count += 1.
- stop_on_fail = 1 with failures at PC 4 and 8 on consecutive cycles -> DONE after PC 4, fail_count = 1, PC 8 not counted.
- max_cycles = 10 with no end_pc beat -> done and timeout at cycle 10 of RUN, pass = 0. Then assert reset mid-run on a restarted run -> all outputs at 0 in the same cycle, and vector memory still readable on the next run.
